// File: rtl/shifter_pkg.sv
// Shared encodings and the decoded-operation record for the shifter operand unit.
package shifter_pkg;

    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Every operand is expressed as rotate-right(data, amt), with bits outside
    // mask replaced by fill; carry is already resolved at decode time.
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] mask;
        logic        fill;
        logic        carry;
    } dec_op_t;

endpackage

// File: rtl/barrel_rotator.sv
// Combinational 32-bit rotate-right; result bits outside mask take the fill value.
module barrel_rotator (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    input  logic [31:0] mask,
    input  logic        fill,
    output logic [31:0] result
);

    logic [31:0] rotated;
    logic [5:0]  wrap_amt;

    // A wrap shift of 32 (amt=0) yields zero, so amt=0 passes data unchanged.
    assign wrap_amt = 6'd32 - {1'b0, amt};
    assign rotated  = (data >> amt) | (data << wrap_amt);
    assign result   = (rotated & mask) | ({32{fill}} & ~mask);

endmodule

// File: rtl/shifter_operand_unit.sv
// Pipelined shifter-operand / immediate generator with valid-ready handshake;
// decode and boundary handling here, the actual shifting in barrel_rotator.
module shifter_operand_unit #(
    parameter int STAGES       = 2,
    parameter int BRANCH_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    input  logic [31:0] rm,
    input  logic [7:0]  rs,
    input  logic        carry_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] operand,
    output logic        carry_out
);
    import shifter_pkg::*;

    function automatic dec_op_t pass_op(input logic [31:0] value, input logic carry);
        dec_op_t op;
        op.data  = value;
        op.amt   = 5'd0;
        op.mask  = '1;
        op.fill  = 1'b0;
        op.carry = carry;
        return op;
    endfunction

    function automatic dec_op_t shift_op(input logic [1:0] sh, input logic [7:0] n,
                                         input logic [31:0] value, input logic cin);
        dec_op_t    op;
        logic [4:0] n5;
        logic       beyond;
        n5     = n[4:0];
        beyond = (n > 8'd32);
        op     = pass_op(value, cin);
        if (n != 8'd0) begin
            case (sh)
                SH_LSL: begin
                    if (n < 8'd32) begin
                        // Left shift by n is a right rotate by 32-n with the low n bits cleared.
                        op.amt   = 5'd0 - n5;
                        op.mask  = 32'hFFFF_FFFF << n5;
                        op.carry = value[5'd0 - n5];
                    end else begin
                        op.mask  = '0;
                        op.carry = beyond ? 1'b0 : value[0];
                    end
                end
                SH_LSR, SH_ASR: begin
                    op.fill = (sh == SH_ASR) && value[31];
                    if (n < 8'd32) begin
                        op.amt   = n5;
                        op.mask  = 32'hFFFF_FFFF >> n5;
                        op.carry = value[n5 - 5'd1];
                    end else begin
                        op.mask  = '0;
                        op.carry = (beyond && sh == SH_LSR) ? 1'b0 : value[31];
                    end
                end
                default: begin
                    // n5=0 wraps the index to 31, giving the multiple-of-32 carry rm[31].
                    op.amt   = n5;
                    op.carry = value[n5 - 5'd1];
                end
            endcase
        end
        return op;
    endfunction

    function automatic dec_op_t imm_shift_op(input logic [1:0] sh, input logic [4:0] n5,
                                             input logic [31:0] value, input logic cin);
        dec_op_t op;
        if (n5 != 5'd0)
            op = shift_op(sh, {3'b000, n5}, value, cin);
        else if (sh == SH_LSL)
            op = pass_op(value, cin);
        else if (sh == SH_ROR)
            op = pass_op({cin, value[31:1]}, value[0]);
        else
            op = shift_op(sh, 8'd32, value, cin);
        return op;
    endfunction

    function automatic logic [31:0] branch_offset(input logic [23:0] imm24);
        logic signed [31:0] offset;
        offset = {{8{imm24[23]}}, imm24};
        return offset <<< BRANCH_SHIFT;
    endfunction

    function automatic dec_op_t decode(input logic [31:0] ins, input logic [31:0] value,
                                       input logic [7:0] amount, input logic cin);
        dec_op_t    op;
        logic [4:0] rot_amt;
        op      = pass_op(32'd0, cin);
        rot_amt = {ins[11:8], 1'b0};
        case (ins[27:25])
            CLS_DP_REG, CLS_LS_REG: begin
                if (!ins[4])
                    op = imm_shift_op(ins[6:5], ins[11:7], value, cin);
                else if (ins[27:25] == CLS_DP_REG) begin
                    if (!ins[7])
                        op = shift_op(ins[6:5], amount, value, cin);
                    else if (ins[22])
                        op.data = {24'd0, ins[11:8], ins[3:0]};
                    else
                        op.data = value;
                end
            end
            CLS_DP_IMM: begin
                op.data = {24'd0, ins[7:0]};
                op.amt  = rot_amt;
                if (rot_amt != 5'd0)
                    op.carry = op.data[rot_amt - 5'd1];
            end
            CLS_LS_IMM: op.data = {20'd0, ins[11:0]};
            CLS_BRANCH: op.data = branch_offset(ins[23:0]);
            default: ;
        endcase
        return op;
    endfunction

    dec_op_t     dec_now;
    dec_op_t     rot_in;
    logic [31:0] rot_result;
    logic        accept;
    logic        adv_out;
    logic        load_out;
    logic        vld_p1;
    logic [31:0] operand_p1;
    logic        carry_p1;
    logic        unused_bits;

    assign unused_bits = ^{instruction[31:28], instruction[24]};
    assign dec_now     = decode(instruction, rm, rs, carry_in);
    assign adv_out     = !vld_p1 || out_ready;
    assign accept      = in_valid && in_ready;

    generate
        if (STAGES == 2) begin : g_two_stage
            dec_op_t dec_p0;
            logic    vld_p0;

            // Stage 0: decoded operation
            always_ff @(posedge clk) begin
                if (!reset_n)
                    vld_p0 <= 1'b0;
                else if (!vld_p0 || adv_out)
                    vld_p0 <= accept;
            end

            always_ff @(posedge clk) begin
                if (accept)
                    dec_p0 <= dec_now;
            end

            assign in_ready = reset_n && (!vld_p0 || adv_out);
            assign rot_in   = dec_p0;
            assign load_out = vld_p0 && adv_out;
        end else begin : g_one_stage
            assign in_ready = reset_n && adv_out;
            assign rot_in   = dec_now;
            assign load_out = accept;
        end
    endgenerate

    barrel_rotator u_rotator (
        .data   (rot_in.data),
        .amt    (rot_in.amt),
        .mask   (rot_in.mask),
        .fill   (rot_in.fill),
        .result (rot_result)
    );

    // Stage 1: rotated operand and carry, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            operand_p1 <= 32'd0;
            carry_p1   <= 1'b0;
        end else begin
            if (adv_out)
                vld_p1 <= load_out;
            if (load_out) begin
                operand_p1 <= rot_result;
                carry_p1   <= rot_in.carry;
            end
        end
    end

    assign out_valid = vld_p1;
    assign operand   = operand_p1;
    assign carry_out = carry_p1;

endmodule

// File: tb/tb_shifter_operand_unit.sv
// Randomised and directed bench for shifter_operand_unit against an arithmetic reference model.
module tb_shifter_operand_unit;

    localparam int STAGES       = 2;
    localparam int BRANCH_SHIFT = 2;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [31:0] rm;
    logic [7:0]  rs;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] operand;
    logic        carry_out;

    int n_cmp = 0;
    int n_bad = 0;

    shifter_operand_unit #(.STAGES(STAGES), .BRANCH_SHIFT(BRANCH_SHIFT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .rm          (rm),
        .rs          (rs),
        .carry_in    (carry_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operand     (operand),
        .carry_out   (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int ND = 14;
    localparam logic [31:0] D_INS [ND] = '{32'h0000_0020, 32'h0000_0060, 32'h0000_0050, 32'h0000_0010,
                                           32'h0200_04FF, 32'h0200_00FF, 32'h0A80_0000, 32'h0040_0A95,
                                           32'h0400_0ABC, 32'h0000_0030, 32'h0000_0000, 32'h0000_0070,
                                           32'h0000_0200, 32'h0000_00C0};
    localparam logic [31:0] D_RM  [ND] = '{32'h8000_0001, 32'h0000_0003, 32'h8000_0000, 32'h8000_0000,
                                           32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678,
                                           32'h0000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000,
                                           32'hF000_0001, 32'h8000_0001};
    localparam logic [7:0]  D_RS  [ND] = '{8'd0, 8'd0, 8'd40, 8'd33, 8'd0, 8'd0, 8'd0, 8'd0,
                                           8'd0, 8'd32, 8'd0, 8'd32, 8'd0, 8'd0};
    localparam logic        D_CIN [ND] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                           1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [31:0] D_OP  [ND] = '{32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000,
                                           32'hFF00_0000, 32'h0000_00FF, 32'hFE00_0000, 32'h0000_00A5,
                                           32'h0000_0ABC, 32'h0000_0000, 32'hDEAD_BEEF, 32'h8000_0000,
                                           32'h0000_0010, 32'hC000_0000};
    localparam logic        D_C   [ND] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Returns {carry, result} of a shift by an unbounded amount using wide arithmetic.
    function automatic logic [32:0] shift_ref(input logic [1:0] sh, input int n,
                                              input logic [31:0] v, input logic cin);
        logic [63:0]        t;
        logic signed [63:0] s;
        if (n == 0) return {cin, v};
        case (sh)
            2'd0: begin t = {32'd0, v} << n; return {t[32], t[31:0]}; end
            2'd1: begin t = {v, 32'd0} >> n; return {t[31], t[63:32]}; end
            2'd2: begin s = $signed({v, 32'd0}) >>> n; return {s[31], s[63:32]}; end
            default: begin t = {v, v} >> (n % 32); return {t[31], t[31:0]}; end
        endcase
    endfunction

    function automatic void model(input logic [31:0] ins, input logic [31:0] v, input logic [7:0] amount,
                                  input logic cin, output logic [31:0] op, output logic c);
        logic [32:0]        r;
        logic [63:0]        t;
        logic signed [31:0] off;
        int                 n5;
        int                 rot;
        op = 32'd0;
        c  = cin;
        n5 = int'(ins[11:7]);
        case (ins[27:25])
            3'b000, 3'b011: begin
                if (ins[4] == 1'b0) begin
                    if (n5 != 0)             r = shift_ref(ins[6:5], n5, v, cin);
                    else if (ins[6:5] == 0)  r = {cin, v};
                    else if (ins[6:5] == 3)  r = {v[0], cin, v[31:1]};
                    else                     r = shift_ref(ins[6:5], 32, v, cin);
                    {c, op} = r;
                end else if (ins[27:25] == 3'b000) begin
                    if (ins[7] == 1'b0) {c, op} = shift_ref(ins[6:5], int'(amount), v, cin);
                    else if (ins[22])   op = {24'd0, ins[11:8], ins[3:0]};
                    else                op = v;
                end
            end
            3'b001: begin
                rot = 2 * int'(ins[11:8]);
                t   = {24'd0, ins[7:0], 24'd0, ins[7:0]} >> rot;
                op  = t[31:0];
                if (rot != 0) c = op[31];
            end
            3'b010: op = {20'd0, ins[11:0]};
            3'b101: begin
                off = {{8{ins[23]}}, ins[23:0]};
                op  = off * (2 ** BRANCH_SHIFT);
            end
            default: ;
        endcase
    endfunction

    task automatic rand_vec(output logic [31:0] ins, output logic [31:0] v, output logic [7:0] amount,
                            output logic cin);
        ins        = $urandom;
        ins[27:25] = 3'($urandom_range(0, 7));
        v          = $urandom;
        cin        = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
            0:       amount = 8'd0;
            1:       amount = 8'd32;
            2:       amount = 8'($urandom_range(1, 31));
            default: amount = 8'($urandom_range(33, 255));
        endcase
    endtask

    // Presents one input to an empty pipeline, waits (bounded) for its result and drains it.
    task automatic run_one(input logic [31:0] i_ins, input logic [31:0] i_rm, input logic [7:0] i_rs,
                           input logic i_cin, output logic [31:0] o_op, output logic o_c, output int o_lat);
        int n;
        instruction = i_ins;
        rm          = i_rm;
        rs          = i_rs;
        carry_in    = i_cin;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        instruction = $urandom;
        rm          = $urandom;
        rs          = 8'($urandom);
        carry_in    = ~i_cin;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        o_op  = operand;
        o_c   = carry_out;
        o_lat = out_valid ? n : -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        instruction = 32'd0;
        rm          = 32'd0;
        rs          = 8'd0;
        carry_in    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (operand !== 32'd0) begin n_bad++; $display("FAIL reset_operand: got %h expected 00000000", operand); end
        n_cmp++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_directed;
        logic [31:0] op;
        logic        c;
        int          lat;
        for (int i = 0; i < ND; i++) begin
            run_one(D_INS[i], D_RM[i], D_RS[i], D_CIN[i], op, c, lat);
            n_cmp++; if (op !== D_OP[i]) begin n_bad++; $display("FAIL directed_operand[%0d]: got %h expected %h", i, op, D_OP[i]); end
            n_cmp++; if (c !== D_C[i]) begin n_bad++; $display("FAIL directed_carry[%0d]: got %b expected %b", i, c, D_C[i]); end
            n_cmp++; if (lat != STAGES) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, STAGES); end
        end
    endtask

    task automatic test_random;
        logic [31:0] ins, v, op, e_op;
        logic [7:0]  amount;
        logic        cin, c, e_c;
        int          lat;
        for (int i = 0; i < 200; i++) begin
            rand_vec(ins, v, amount, cin);
            model(ins, v, amount, cin, e_op, e_c);
            run_one(ins, v, amount, cin, op, c, lat);
            n_cmp++;
            if (op !== e_op || c !== e_c || lat != STAGES) begin
                n_bad++;
                $display("FAIL random[%0d] ins=%h rm=%h rs=%0d cin=%b: got op=%h c=%b lat=%0d expected op=%h c=%b lat=%0d",
                         i, ins, v, amount, cin, op, c, lat, e_op, e_c, STAGES);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] s_ins [6];
        logic [31:0] s_rm  [6];
        logic [7:0]  s_rs  [6];
        logic        s_c   [6];
        logic [31:0] q_op  [$];
        logic        q_c   [$];
        int          q_cyc [$];
        logic [31:0] e_op, held_op;
        logic        e_c, held_c, held;
        int          sent, got, lat;
        for (int i = 0; i < 6; i++) rand_vec(s_ins[i], s_rm[i], s_rs[i], s_c[i]);
        sent = 0;
        got  = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                instruction = s_ins[sent];
                rm          = s_rm[sent];
                rs          = s_rs[sent];
                carry_in    = s_c[sent];
            end
            #1;
            if (held) begin
                n_cmp++;
                if (out_valid !== 1'b1 || operand !== held_op || carry_out !== held_c) begin
                    n_bad++;
                    $display("FAIL b2b_hold cyc %0d: got v=%b op=%h c=%b expected v=1 op=%h c=%b", cyc, out_valid, operand, carry_out, held_op, held_c);
                end
            end
            if (out_valid) begin
                if (q_op.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b2b_spurious cyc %0d: got out_valid=1 op=%h expected out_valid=0", cyc, operand);
                end else begin
                    if (!held) begin
                        lat = cyc - q_cyc[0];
                        n_cmp++;
                        if ((got == 0) ? (lat != STAGES) : (lat < STAGES)) begin
                            n_bad++;
                            $display("FAIL b2b_latency item %0d: got %0d expected %0d", got, lat, STAGES);
                        end
                    end
                    if (out_ready) begin
                        e_op = q_op.pop_front();
                        e_c  = q_c.pop_front();
                        void'(q_cyc.pop_front());
                        n_cmp++;
                        if (operand !== e_op || carry_out !== e_c) begin
                            n_bad++;
                            $display("FAIL b2b_result item %0d: got op=%h c=%b expected op=%h c=%b", got, operand, carry_out, e_op, e_c);
                        end
                        got++;
                        held = 1'b0;
                    end else begin
                        held    = 1'b1;
                        held_op = operand;
                        held_c  = carry_out;
                    end
                end
            end else begin
                held = 1'b0;
            end
            if (in_valid && in_ready) begin
                model(s_ins[sent], s_rm[sent], s_rs[sent], s_c[sent], e_op, e_c);
                q_op.push_back(e_op);
                q_c.push_back(e_c);
                q_cyc.push_back(cyc);
                sent++;
            end else if (in_valid) begin
                instruction = $urandom;
                rm          = $urandom;
                carry_in    = ~carry_in;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (got != 6) begin n_bad++; $display("FAIL b2b_count: got %0d results expected 6", got); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] ins, v, op, e_op;
        logic [7:0]  amount;
        logic        cin, c, e_c;
        int          lat;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_vec(ins, v, amount, cin);
            instruction = ins; rm = v; rs = amount; carry_in = cin;
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL midreset_prefill: got out_valid=%b expected 1", out_valid); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (operand !== 32'd0) begin n_bad++; $display("FAIL midreset_operand: got %h expected 00000000", operand); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_in_ready: got %b expected 0", in_ready); end
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_stale cyc %0d: got out_valid=%b expected 0", i, out_valid); end
        end
        rand_vec(ins, v, amount, cin);
        model(ins, v, amount, cin, e_op, e_c);
        run_one(ins, v, amount, cin, op, c, lat);
        n_cmp++;
        if (op !== e_op || c !== e_c || lat != STAGES) begin
            n_bad++;
            $display("FAIL midreset_recover: got op=%h c=%b lat=%0d expected op=%h c=%b lat=%0d", op, c, lat, e_op, e_c, STAGES);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
